turn_sequencer: RTL and testbench
=================================

Name: turn_sequencer

Overview:
- Game-flow controller for the two-player ship game; sequences the board store and the inter-board serial link.
- Placement phase: enables cell picking until SHIP_CELLS ships are placed and both sides report ready.
- Battle phase: alternates turns, sends our shot addresses, forwards incoming shots to the board store and returns its verdict, and tracks hits to declare win/lose.
- Sits between mouse/click logic, the board store and the UART tx/rx wrapper.

Parameters:
SHIP_CELLS, 10, ship cells per side; placement target and hits needed to win
TIMEOUT, 1_000_000, clk cycles to wait for a peer reply before resending

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
frame_tick  in  1  one-cycle pulse marking the board-store update slot
host_first  in  1  1 = this side shoots first
ship_count  in  4  cells placed, from board store
click  in  1  one-cycle left-click pulse
click_addr  in  8  clicked cell {row[3:0], col[3:0]}
rx_valid  in  1  one-cycle pulse: rx_data valid
rx_data  in  8  received byte
tx_busy  in  1  UART transmitter busy
board_msg  in  2  board verdict: 11 miss, 10 hit, 00 repeat/invalid
place_en  out  1  placement picking enabled
fire_en  out  1  aiming on opponent grid enabled
check_addr  out  8  incoming shot address to board store
check_valid  out  1  check_addr valid, held until consumed
result_in  out  2  verdict of our last shot, for the opponent-grid overlay
result_valid  out  1  one-cycle pulse with result_in
tx_start  out  1  one-cycle send strobe
tx_data  out  8  byte to send
game_over  out  1  sticky end-of-game flag
win  out  1  valid when game_over
state_dbg  out  4  current state code

Behaviour:
Link bytes:
- READY = 8'hF0.
- SHOT = {row, col}, with row and col each 0..9.
- RESULT = {6'b110000, verdict}.
- Any other byte is ignored.

Reset values:
- All outputs 0; hit counters 0; state PLACE (code 0).

State PLACE (0):
- place_en = 1.
- When ship_count >= SHIP_CELLS: place_en = 0, go to SEND_READY.

State SEND_READY (1):
- Wait for tx_busy = 0, then pulse tx_start with READY, go to WAIT_PEER.

State WAIT_PEER (2):
- On rx READY: go to MY_TURN if host_first = 1, else THEIR_TURN.
- A READY that arrived during PLACE or SEND_READY is latched in a peer_ready flag and honoured here.

State MY_TURN (3):
- fire_en = 1.
- On click with row <= 9 and col <= 9: latch the address, go to SEND_SHOT.
- Off-grid clicks are ignored.

State SEND_SHOT (4):
- When tx_busy = 0: pulse tx_start with the latched address, clear the timeout counter, go to WAIT_RESULT.

State WAIT_RESULT (5):
- On rx RESULT, the verdict sets result_in and pulses result_valid for 1 cycle.
  - Verdict 10: increment hits_given. If hits_given reaches SHIP_CELLS, go to WIN; else go to THEIR_TURN.
  - Verdict 11: go to THEIR_TURN.
  - Verdict 00 (repeat): go back to MY_TURN.
- If TIMEOUT expires with no RESULT: go to SEND_SHOT (resend).

State THEIR_TURN (6):
- On rx SHOT with row <= 9 and col <= 9: check_addr = byte, check_valid = 1, go to CHECK.
- Invalid addresses are ignored.

State CHECK (7):
- Hold check_valid until the first frame_tick.
- The board store updates on that tick; on the next cycle sample board_msg, drop check_valid, go to SEND_RESULT.

State SEND_RESULT (8):
- When tx_busy = 0: pulse tx_start with RESULT(board_msg).
  - If board_msg = 10: increment hits_taken. If hits_taken reaches SHIP_CELLS, go to LOSE; else go to MY_TURN.
  - If board_msg = 11: go to MY_TURN.
  - If board_msg = 00: go to THEIR_TURN.

States WIN (9) and LOSE (10):
- Terminal. game_over = 1; win = 1 in WIN, 0 in LOSE.
- fire_en and place_en stay 0.
- Only reset exits.

Common rules:
- tx_start is never asserted while tx_busy = 1.
- tx_data is stable from the tx_start cycle until tx_busy falls.
- A click and rx_valid in the same cycle: each is handled only by the state that consumes it.
- Unexpected bytes in any state are dropped without a state change.
- Hit counters are 4-bit, saturate at SHIP_CELLS and never wrap.
- Reset mid-transfer returns to PLACE at once; any partially sent byte is abandoned.
- Encodings 11–15 recover to PLACE.

Test Plan:
- Placement and start: ship_count steps 0→10 → place_en falls; READY sent once. With rx READY and host_first = 1 → MY_TURN (3), fire_en = 1.
- Our shot, hit: click at 8'h34 → tx_data = 8'h34. Then rx 8'hC2 → result_valid with result_in = 10, then THEIR_TURN.
- Incoming shot: rx 8'h57 → check_addr = 8'h57 held until frame_tick. With board_msg = 11 → tx 8'hC3, then MY_TURN.
- Timeout and repeat: no reply for TIMEOUT cycles → 8'h34 resent. rx 8'hC0 → back to MY_TURN.
- End of game: 10 hit results received → WIN, game_over = 1, win = 1. On the peer side, 10 hits taken → LOSE, win = 0. Further clicks are ignored.
- Robustness: rx 8'hAB, an off-grid click 8'h3C, and a click pulse while tx_busy = 1 → ignored or deferred. Async reset (rst = 0) in WAIT_RESULT → all outputs 0 immediately, state PLACE.

Source files
------------

// File: rtl/turn_sequencer.sv
// turn_sequencer: placement/battle flow controller between click logic, board store and UART link
module turn_sequencer #(
  parameter int SHIP_CELLS = 10,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_frame_tick,
  input  logic       i_host_first,
  input  logic [3:0] i_ship_count,
  input  logic       i_click,
  input  logic [7:0] i_click_addr,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rx_data,
  input  logic       i_tx_busy,
  input  logic [1:0] i_board_msg,
  output logic       o_place_en,
  output logic       o_fire_en,
  output logic [7:0] o_check_addr,
  output logic       o_check_valid,
  output logic [1:0] o_result_in,
  output logic       o_result_valid,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  output logic       o_game_over,
  output logic       o_win,
  output logic [3:0] o_state_dbg
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] SC = 4'(SHIP_CELLS);
  typedef enum logic [3:0] {
    PLACE, SEND_READY, WAIT_PEER, MY_TURN, SEND_SHOT, WAIT_RESULT,
    THEIR_TURN, CHECK, SEND_RESULT, WIN, LOSE
  } state_t;
  state_t r_state, w_next;
  logic [TW-1:0] r_timer;
  logic [7:0] r_shot_addr, r_tx_data, w_tx_byte;
  logic [3:0] r_hits_given, r_hits_taken;
  logic [1:0] r_verdict;
  logic r_peer_ready, r_ticked, w_send;
  logic w_rx_ready, w_rx_shot, w_rx_result, w_click_ok, w_give_hit, w_take_hit;
  assign w_rx_ready  = i_rx_valid && i_rx_data == 8'hF0;
  assign w_rx_shot   = i_rx_valid && i_rx_data[7:4] <= 4'd9 && i_rx_data[3:0] <= 4'd9;
  assign w_rx_result = i_rx_valid && i_rx_data[7:2] == 6'b110000 && i_rx_data[1:0] != 2'b01;
  assign w_click_ok  = i_click && i_click_addr[7:4] <= 4'd9 && i_click_addr[3:0] <= 4'd9;
  assign w_give_hit  = r_state == WAIT_RESULT && w_rx_result && i_rx_data[1:0] == 2'b10;
  assign w_take_hit  = w_send && r_state == SEND_RESULT && r_verdict == 2'b10;
  assign o_tx_start  = w_send;
  assign o_tx_data   = w_tx_byte;
  assign o_state_dbg = r_state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= PLACE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_send = 1'b0;
    w_tx_byte = r_tx_data;
    case (r_state)
      PLACE:       w_next = (i_ship_count >= SC) ? SEND_READY : PLACE;
      SEND_READY:  if (!i_tx_busy) begin
                     w_send = 1'b1;
                     w_tx_byte = 8'hF0;
                     w_next = WAIT_PEER;
                   end
      WAIT_PEER:   if (w_rx_ready || r_peer_ready) w_next = i_host_first ? MY_TURN : THEIR_TURN;
      MY_TURN:     if (w_click_ok) w_next = SEND_SHOT;
      SEND_SHOT:   if (!i_tx_busy) begin
                     w_send = 1'b1;
                     w_tx_byte = r_shot_addr;
                     w_next = WAIT_RESULT;
                   end
      WAIT_RESULT: if (w_rx_result)
                     w_next = (i_rx_data[1:0] == 2'b00) ? MY_TURN :
                              (w_give_hit && r_hits_given >= SC - 4'd1) ? WIN : THEIR_TURN;
                   else if (r_timer == TW'(TIMEOUT - 1)) w_next = SEND_SHOT;
      THEIR_TURN:  if (w_rx_shot) w_next = CHECK;
      CHECK:       if (r_ticked) w_next = SEND_RESULT;
      SEND_RESULT: if (!i_tx_busy) begin
                     w_send = 1'b1;
                     w_tx_byte = {6'b110000, r_verdict};
                     w_next = (r_verdict == 2'b10 && r_hits_taken >= SC - 4'd1) ? LOSE :
                              r_verdict[1] ? MY_TURN : THEIR_TURN;
                   end
      WIN, LOSE:   w_next = r_state;
      default:     w_next = PLACE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      o_place_en <= 1'b0;
      o_fire_en <= 1'b0;
      o_game_over <= 1'b0;
      o_win <= 1'b0;
      o_check_addr <= '0;
      o_check_valid <= 1'b0;
      o_result_in <= '0;
      o_result_valid <= 1'b0;
      r_timer <= '0;
      r_shot_addr <= '0;
      r_tx_data <= '0;
      r_hits_given <= '0;
      r_hits_taken <= '0;
      r_verdict <= '0;
      r_peer_ready <= 1'b0;
      r_ticked <= 1'b0;
    end else begin
      o_place_en <= w_next == PLACE;
      o_fire_en <= w_next == MY_TURN;
      o_game_over <= w_next == WIN || w_next == LOSE;
      o_win <= w_next == WIN;
      o_result_valid <= r_state == WAIT_RESULT && w_rx_result;
      if (r_state == WAIT_RESULT && w_rx_result) o_result_in <= i_rx_data[1:0];
      if (w_send) r_tx_data <= w_tx_byte;
      r_timer <= (r_state == WAIT_RESULT) ? r_timer + 1'b1 : '0;
      r_peer_ready <= (r_state == WAIT_PEER) ? 1'b0 :
                      r_peer_ready | (w_rx_ready && (r_state == PLACE || r_state == SEND_READY));
      if (r_state == MY_TURN && w_click_ok) r_shot_addr <= i_click_addr;
      if (r_state == THEIR_TURN && w_rx_shot) begin
        o_check_addr <= i_rx_data;
        o_check_valid <= 1'b1;
      end
      r_ticked <= r_state == CHECK && (r_ticked || i_frame_tick);
      if (r_state == CHECK && r_ticked) begin
        r_verdict <= i_board_msg;
        o_check_valid <= 1'b0;
      end
      if (w_give_hit && r_hits_given < SC) r_hits_given <= r_hits_given + 4'd1;
      if (w_take_hit && r_hits_taken < SC) r_hits_taken <= r_hits_taken + 4'd1;
    end
endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: directed game scenarios checked against a game-rule model every cycle
module tb_turn_sequencer;
  localparam int SC = 10;
  localparam int TO = 40;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_frame_tick = 0, i_host_first = 1, i_click = 0, i_rx_valid = 0, i_tx_busy;
  logic [3:0] i_ship_count = 0;
  logic [7:0] i_click_addr = 0, i_rx_data = 0;
  logic [1:0] i_board_msg = 2'b11;
  logic o_place_en, o_fire_en, o_check_valid, o_result_valid, o_tx_start, o_game_over, o_win;
  logic [7:0] o_check_addr, o_tx_data;
  logic [1:0] o_result_in;
  logic [3:0] o_state_dbg;
  int errs = 0, checks = 0;
  int busy_cnt = 0;
  logic hold_busy = 0, start_q = 0;
  logic [7:0] tx_log[$];
  int m_st, m_given, m_taken, m_wait;
  logic m_peer, m_cvalid, m_tick_seen, m_resv, m_place, m_fire, m_over, m_win;
  logic [7:0] m_shot, m_caddr, m_last_tx;
  logic [1:0] m_verdict, m_res;

  turn_sequencer #(.SHIP_CELLS(SC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .i_frame_tick(i_frame_tick), .i_host_first(i_host_first),
    .i_ship_count(i_ship_count), .i_click(i_click), .i_click_addr(i_click_addr),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .i_tx_busy(i_tx_busy),
    .i_board_msg(i_board_msg), .o_place_en(o_place_en), .o_fire_en(o_fire_en),
    .o_check_addr(o_check_addr), .o_check_valid(o_check_valid), .o_result_in(o_result_in),
    .o_result_valid(o_result_valid), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .o_game_over(o_game_over), .o_win(o_win), .o_state_dbg(o_state_dbg));

  always #5 clk = ~clk;
  assign i_tx_busy = (busy_cnt != 0) || hold_busy;
  always @(negedge clk) begin
    start_q = o_tx_start;
    if (o_tx_start) tx_log.push_back(o_tx_data);
  end
  always @(posedge clk) busy_cnt <= start_q ? 4 : (busy_cnt > 0 ? busy_cnt - 1 : 0);

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : mdl
    int nx;
    bit snd, rdy, shot, res, ck;
    logic [7:0] b;
    logic [1:0] v;
    if (!rst_n) begin
      m_st = 0; m_given = 0; m_taken = 0; m_wait = 0; m_peer = 0; m_cvalid = 0;
      m_tick_seen = 0; m_resv = 0; m_place = 0; m_fire = 0; m_over = 0; m_win = 0;
      m_shot = 0; m_caddr = 0; m_last_tx = 0; m_verdict = 0; m_res = 0;
    end else begin
      nx = m_st; snd = 0; b = 0; v = i_rx_data[1:0];
      rdy = i_rx_valid && i_rx_data == 8'hF0;
      shot = i_rx_valid && i_rx_data[7:4] < 10 && i_rx_data[3:0] < 10;
      res = i_rx_valid && i_rx_data[7:2] == 6'b110000 && v != 2'b01;
      ck = i_click && i_click_addr[7:4] < 10 && i_click_addr[3:0] < 10;
      m_resv = 0;
      if ((m_st == 0 || m_st == 1) && rdy) m_peer = 1;
      if (m_st == 0 && i_ship_count >= SC) nx = 1;
      if (m_st == 1 && !i_tx_busy) begin snd = 1; b = 8'hF0; nx = 2; end
      if (m_st == 2 && (rdy || m_peer)) begin nx = i_host_first ? 3 : 6; m_peer = 0; end
      if (m_st == 3 && ck) begin m_shot = i_click_addr; nx = 4; end
      if (m_st == 4 && !i_tx_busy) begin snd = 1; b = m_shot; nx = 5; m_wait = 0; end
      if (m_st == 5) begin
        m_wait++;
        if (res) begin
          m_res = v; m_resv = 1;
          if (v == 2'b10) begin
            if (m_given < SC) m_given++;
            nx = (m_given >= SC) ? 9 : 6;
          end else nx = (v == 2'b11) ? 6 : 3;
        end else if (m_wait == TO) nx = 4;
      end
      if (m_st == 6 && shot) begin m_caddr = i_rx_data; m_cvalid = 1; m_tick_seen = 0; nx = 7; end
      if (m_st == 7) begin
        if (m_tick_seen) begin m_verdict = i_board_msg; m_cvalid = 0; nx = 8; end
        else if (i_frame_tick) m_tick_seen = 1;
      end
      if (m_st == 8 && !i_tx_busy) begin
        snd = 1; b = {6'b110000, m_verdict};
        if (m_verdict == 2'b10) begin
          if (m_taken < SC) m_taken++;
          nx = (m_taken >= SC) ? 10 : 3;
        end else nx = (m_verdict == 2'b11) ? 3 : 6;
      end
      if (snd) m_last_tx = b;
      m_st = nx;
      m_place = nx == 0; m_fire = nx == 3; m_over = nx >= 9; m_win = nx == 9;
    end
  end

  always @(negedge clk) begin : cmp
    bit es;
    logic [7:0] eb;
    es = (m_st == 1 || m_st == 4 || m_st == 8) && !i_tx_busy;
    eb = !es ? m_last_tx : m_st == 1 ? 8'hF0 : m_st == 4 ? m_shot : {6'b110000, m_verdict};
    chk("state_dbg", o_state_dbg, m_st);
    chk("place_en", o_place_en, m_place);
    chk("fire_en", o_fire_en, m_fire);
    chk("check_valid", o_check_valid, m_cvalid);
    chk("check_addr", o_check_addr, m_caddr);
    chk("result_valid", o_result_valid, m_resv);
    chk("result_in", o_result_in, m_res);
    chk("tx_start", o_tx_start, es);
    chk("tx_data", o_tx_data, eb);
    chk("game_over", o_game_over, m_over);
    chk("win", o_win, m_win);
    if (o_tx_start) chk("tx_start_while_busy", i_tx_busy, 0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic rx(input logic [7:0] d);
    i_rx_valid = 1; i_rx_data = d; tick; i_rx_valid = 0;
  endtask
  task automatic click(input logic [7:0] a);
    i_click = 1; i_click_addr = a; tick; i_click = 0;
  endtask
  task automatic ftick(input logic [1:0] msg);
    i_board_msg = msg; i_frame_tick = 1; tick; i_frame_tick = 0;
  endtask
  task automatic wait_state(input int s);
    int n = 0;
    while (o_state_dbg != s && n < 300) begin tick; n++; end
    chk($sformatf("reach_state_%0d", s), o_state_dbg, s);
  endtask
  task automatic wait_tx(input int cnt);
    int n = 0;
    while (tx_log.size() < cnt && n < 300) begin tick; n++; end
    chk($sformatf("tx_count_%0d", cnt), tx_log.size(), cnt);
  endtask

  initial begin
    int base;
    repeat (2) tick;
    chk("rst_state", o_state_dbg, 0);
    chk("rst_place_en", o_place_en, 0);
    chk("rst_tx_start", o_tx_start, 0);
    rst_n = 1;
    tick;
    chk("place_en_on", o_place_en, 1);
    rx(8'hAB);
    rx(8'hF0);
    for (int n = 1; n <= 10; n++) begin i_ship_count = 4'(n); tick; end
    chk("place_en_off", o_place_en, 0);
    wait_state(3);
    chk("fire_en_my_turn", o_fire_en, 1);
    chk("ready_sent_once", tx_log.size(), 1);
    chk("ready_byte", tx_log[0], 8'hF0);
    click(8'h3C);
    tick;
    chk("offgrid_ignored", o_state_dbg, 3);
    hold_busy = 1;
    click(8'h34);
    repeat (3) tick;
    chk("shot_deferred_busy", o_state_dbg, 4);
    hold_busy = 0;
    wait_tx(2);
    chk("shot_byte", tx_log[1], 8'h34);
    wait_state(5);
    repeat (2) tick;
    rx(8'hC2);
    chk("hit_result_valid", o_result_valid, 1);
    chk("hit_result_in", o_result_in, 2);
    chk("after_hit_their_turn", o_state_dbg, 6);
    rx(8'hAB);
    rx(8'h57);
    chk("check_addr_57", o_check_addr, 8'h57);
    repeat (3) tick;
    chk("check_valid_held", o_check_valid, 1);
    ftick(2'b11);
    wait_tx(3);
    chk("miss_result_byte", tx_log[2], 8'hC3);
    wait_state(3);
    click(8'h34);
    wait_tx(4);
    wait_tx(5);
    chk("timeout_resend", tx_log[4], 8'h34);
    wait_state(5);
    rx(8'hC0);
    chk("repeat_back_my_turn", o_state_dbg, 3);
    for (int k = 1; k < 10; k++) begin
      if (k == 1) begin i_rx_valid = 1; i_rx_data = 8'h57; end
      click({4'(k), 4'h0});
      i_rx_valid = 0;
      wait_state(5);
      rx(8'hC2);
      if (k < 9) begin
        wait_state(6);
        rx({4'(k), 4'h1});
        tick;
        ftick(2'b11);
        wait_state(3);
      end
    end
    wait_state(9);
    chk("win_game_over", o_game_over, 1);
    chk("win_flag", o_win, 1);
    chk("win_fire_off", o_fire_en, 0);
    click(8'h55);
    repeat (2) tick;
    chk("win_terminal", o_state_dbg, 9);
    rst_n = 0;
    tick;
    rst_n = 1;
    i_host_first = 0;
    wait_state(2);
    rx(8'hF0);
    chk("peer_their_turn", o_state_dbg, 6);
    for (int k = 0; k < 10; k++) begin
      base = tx_log.size();
      rx({4'(k), 4'h2});
      ftick(2'b10);
      wait_tx(base + 1);
      if (k == 0) chk("hit_taken_byte", tx_log[base], 8'hC2);
      if (k < 9) begin
        wait_state(3);
        click({4'(k), 4'h3});
        wait_state(5);
        rx(8'hC3);
      end
    end
    wait_state(10);
    chk("lose_game_over", o_game_over, 1);
    chk("lose_win", o_win, 0);
    chk("lose_place_off", o_place_en, 0);
    rst_n = 0;
    tick;
    rst_n = 1;
    i_host_first = 1;
    wait_state(2);
    rx(8'hF0);
    wait_state(3);
    click(8'h21);
    wait_state(5);
    #2 rst_n = 0;
    #1;
    chk("async_state", o_state_dbg, 0);
    chk("async_tx_start", o_tx_start, 0);
    chk("async_tx_data", o_tx_data, 0);
    chk("async_fire_en", o_fire_en, 0);
    chk("async_place_en", o_place_en, 0);
    chk("async_game_over", o_game_over, 0);
    tick;
    rst_n = 1;
    repeat (2) tick;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
